// File: rtl/hazard_stall_unit.sv
// hazard_stall_unit: load-use/branch stall, memory-wait freeze and wait-timeout FSM
// Define HAZARD_STATS_EN to build the StallCount/FreezeCount statistics counters.
module hazard_stall_unit #(
    parameter int MAX_WAIT = 16,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       IF_Id_Rs,
    input  logic [4:0]       IF_Id_Rt,
    input  logic             IF_Id_UsesRt,
    input  logic             IF_Id_Branch,
    input  logic             ID_Ex_MemRead,
    input  logic             ID_Ex_Regwrite,
    input  logic [4:0]       ID_Ex_WriteReg,
    input  logic             EX_MemMemRead,
    input  logic [4:0]       EX_MemWriteReg,
    input  logic             MemReq,
    input  logic             MemReady,
    output logic             PCWrite,
    output logic             IF_IdWrite,
    output logic             ID_ExBubble,
    output logic             Freeze,
    output logic             MemTimeout,
    output logic [CNT_W-1:0] StallCount,
    output logic [CNT_W-1:0] FreezeCount
);
    localparam int WW = $clog2(MAX_WAIT + 1);
    localparam logic [WW-1:0] MAX_CNT = WW'(MAX_WAIT);
    typedef enum logic {RUN, WAIT} state_t;
    state_t state;
    logic [WW-1:0] waitCnt;
    logic exMatch, memMatch, loadUse, branchHaz, frz, stall;
    assign exMatch = (ID_Ex_WriteReg != 5'd0) &&
                     (ID_Ex_WriteReg == IF_Id_Rs || (IF_Id_UsesRt && ID_Ex_WriteReg == IF_Id_Rt));
    assign memMatch = (EX_MemWriteReg != 5'd0) &&
                      (EX_MemWriteReg == IF_Id_Rs || (IF_Id_UsesRt && EX_MemWriteReg == IF_Id_Rt));
    assign loadUse = ID_Ex_MemRead && exMatch;
    assign branchHaz = IF_Id_Branch && ((ID_Ex_Regwrite && exMatch) || (EX_MemMemRead && memMatch));
    assign frz = MemReq && !MemReady;
    assign stall = loadUse || branchHaz;
    // Reset forces a bubble so ID/EX is flushed while the pipeline keeps fetching.
    assign PCWrite = rst || (!frz && !stall);
    assign IF_IdWrite = PCWrite;
    assign ID_ExBubble = rst || (!frz && stall);
    assign Freeze = !rst && frz;
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= RUN;
            waitCnt <= '0;
            MemTimeout <= 1'b0;
        end else if (state == RUN) begin
            if (frz) begin
                state <= WAIT;
                waitCnt <= '0;
            end
        end else begin
            if (!frz) state <= RUN;
            if (waitCnt != MAX_CNT) waitCnt <= waitCnt + WW'(1);
            if (waitCnt == MAX_CNT - WW'(1)) MemTimeout <= 1'b1;
        end
    end
`ifdef HAZARD_STATS_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            StallCount <= '0;
            FreezeCount <= '0;
        end else begin
            if (ID_ExBubble && StallCount != '1) StallCount <= StallCount + CNT_W'(1);
            if (Freeze && FreezeCount != '1) FreezeCount <= FreezeCount + CNT_W'(1);
        end
    end
`else
    assign StallCount = '0;
    assign FreezeCount = '0;
`endif
endmodule

// File: tb/tb_hazard_stall_unit.sv
// tb_hazard_stall_unit: vector table, hand sequences and randomized run against a behavioural model
module tb_hazard_stall_unit;
    localparam int MAXW = 3;
    localparam int CW = 4;
    localparam int SAT = 2 ** CW - 1;
`ifdef HAZARD_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif
    logic clk = 1'b0;
    logic rst;
    logic [4:0] IF_Id_Rs, IF_Id_Rt, ID_Ex_WriteReg, EX_MemWriteReg;
    logic IF_Id_UsesRt, IF_Id_Branch, ID_Ex_MemRead, ID_Ex_Regwrite, EX_MemMemRead, MemReq, MemReady;
    logic PCWrite, IF_IdWrite, ID_ExBubble, Freeze, MemTimeout;
    logic [CW-1:0] StallCount, FreezeCount;
    int tests = 0;
    int fails = 0;
    bit mWait, mTo;
    int mCyc, mStall, mFreeze;

    hazard_stall_unit #(.MAX_WAIT(MAXW), .CNT_W(CW)) dut (
        .clk(clk), .rst(rst), .IF_Id_Rs(IF_Id_Rs), .IF_Id_Rt(IF_Id_Rt), .IF_Id_UsesRt(IF_Id_UsesRt),
        .IF_Id_Branch(IF_Id_Branch), .ID_Ex_MemRead(ID_Ex_MemRead), .ID_Ex_Regwrite(ID_Ex_Regwrite),
        .ID_Ex_WriteReg(ID_Ex_WriteReg), .EX_MemMemRead(EX_MemMemRead), .EX_MemWriteReg(EX_MemWriteReg),
        .MemReq(MemReq), .MemReady(MemReady), .PCWrite(PCWrite), .IF_IdWrite(IF_IdWrite),
        .ID_ExBubble(ID_ExBubble), .Freeze(Freeze), .MemTimeout(MemTimeout),
        .StallCount(StallCount), .FreezeCount(FreezeCount)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [4:0] rs, rt;
        logic usesRt, branch, exMemRead, exRegWrite;
        logic [4:0] exWr;
        logic memMemRead;
        logic [4:0] memWr;
        logic memReq, memReady;
        logic [3:0] exp;
    } vec_t;
    vec_t vecs[12];

    function automatic vec_t mk(input logic [4:0] rs, input logic [4:0] rt, input logic usesRt,
                                input logic branch, input logic exMemRead, input logic exRegWrite,
                                input logic [4:0] exWr, input logic memMemRead, input logic [4:0] memWr,
                                input logic memReq, input logic memReady, input logic [3:0] exp);
        vec_t v;
        v.rs = rs; v.rt = rt; v.usesRt = usesRt; v.branch = branch; v.exMemRead = exMemRead;
        v.exRegWrite = exRegWrite; v.exWr = exWr; v.memMemRead = memMemRead; v.memWr = memWr;
        v.memReq = memReq; v.memReady = memReady; v.exp = exp;
        return v;
    endfunction

    // Expected {PCWrite, IF_IdWrite, ID_ExBubble, Freeze} from the hazard rules.
    function automatic logic [3:0] modelComb();
        logic [4:0] srcs[$];
        bit lu = 1'b0;
        bit br = 1'b0;
        if (rst) return 4'b1110;
        srcs.push_back(IF_Id_Rs);
        if (IF_Id_UsesRt) srcs.push_back(IF_Id_Rt);
        foreach (srcs[i]) if (srcs[i] != 5'd0) begin
            if (ID_Ex_MemRead && srcs[i] == ID_Ex_WriteReg) lu = 1'b1;
            if (IF_Id_Branch && ID_Ex_Regwrite && srcs[i] == ID_Ex_WriteReg) br = 1'b1;
            if (IF_Id_Branch && EX_MemMemRead && srcs[i] == EX_MemWriteReg) br = 1'b1;
        end
        if (MemReq && !MemReady) return 4'b0001;
        if (lu || br) return 4'b0010;
        return 4'b1100;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step(input string tag, input bit useWant, input logic [3:0] want);
        logic [3:0] m;
        #1;
        m = modelComb();
        check({tag, " comb"}, 32'({PCWrite, IF_IdWrite, ID_ExBubble, Freeze}), 32'(useWant ? want : m));
        check({tag, " timeout"}, 32'(MemTimeout), 32'(mTo));
        check({tag, " stallcnt"}, 32'(StallCount), STATS ? 32'(mStall) : 32'd0);
        check({tag, " freezecnt"}, 32'(FreezeCount), STATS ? 32'(mFreeze) : 32'd0);
        if (rst) begin
            mWait = 0; mCyc = 0; mTo = 0; mStall = 0; mFreeze = 0;
        end else begin
            if (m[1] && mStall < SAT) mStall++;
            if (m[0] && mFreeze < SAT) mFreeze++;
            if (!mWait) begin
                if (MemReq && !MemReady) begin mWait = 1; mCyc = 0; end
            end else begin
                mCyc++;
                if (mCyc >= MAXW) mTo = 1;
                if (!(MemReq && !MemReady)) mWait = 0;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        IF_Id_Rs = 0; IF_Id_Rt = 0; IF_Id_UsesRt = 0; IF_Id_Branch = 0; ID_Ex_MemRead = 0;
        ID_Ex_Regwrite = 0; ID_Ex_WriteReg = 0; EX_MemMemRead = 0; EX_MemWriteReg = 0;
        MemReq = 0; MemReady = 0;
    endtask

    task automatic doReset();
        rst = 1;
        step("reset", 1, 4'b1110);
        rst = 0;
    endtask

    initial begin
        idle();
        rst = 1;
        @(posedge clk);
        #1;
        doReset();
        check("reset timeout", 32'(MemTimeout), 32'd0);
        //            rs rt uRt br exMR exRW exWr memMR memWr req rdy exp
        vecs[0]  = mk(5, 0, 0, 0, 1, 1, 5, 0, 0, 0, 0, 4'b0010);
        vecs[1]  = mk(0, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0, 4'b1100);
        vecs[2]  = mk(1, 7, 0, 0, 1, 1, 7, 0, 0, 0, 0, 4'b1100);
        vecs[3]  = mk(1, 7, 1, 0, 1, 1, 7, 0, 0, 0, 0, 4'b0010);
        vecs[4]  = mk(3, 0, 1, 1, 0, 1, 3, 0, 0, 0, 0, 4'b0010);
        vecs[5]  = mk(3, 4, 1, 1, 0, 0, 0, 1, 3, 0, 0, 4'b0010);
        vecs[6]  = mk(3, 0, 0, 0, 0, 0, 0, 1, 3, 0, 0, 4'b1100);
        vecs[7]  = mk(0, 0, 1, 1, 0, 1, 0, 0, 0, 0, 0, 4'b1100);
        vecs[8]  = mk(5, 0, 0, 0, 1, 1, 5, 0, 0, 1, 0, 4'b0001);
        vecs[9]  = mk(5, 0, 0, 0, 1, 1, 5, 0, 0, 1, 1, 4'b0010);
        vecs[10] = mk(2, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 4'b1100);
        vecs[11] = mk(6, 0, 0, 0, 0, 1, 6, 0, 0, 0, 0, 4'b1100);
        foreach (vecs[i]) begin
            IF_Id_Rs = vecs[i].rs; IF_Id_Rt = vecs[i].rt; IF_Id_UsesRt = vecs[i].usesRt;
            IF_Id_Branch = vecs[i].branch; ID_Ex_MemRead = vecs[i].exMemRead;
            ID_Ex_Regwrite = vecs[i].exRegWrite; ID_Ex_WriteReg = vecs[i].exWr;
            EX_MemMemRead = vecs[i].memMemRead; EX_MemWriteReg = vecs[i].memWr;
            MemReq = vecs[i].memReq; MemReady = vecs[i].memReady;
            step($sformatf("vec%0d", i), 1, vecs[i].exp);
        end
        // Load-use: lw $5 in EX then moves to MEM while ID still reads $5.
        idle();
        doReset();
        IF_Id_Rs = 5; ID_Ex_MemRead = 1; ID_Ex_Regwrite = 1; ID_Ex_WriteReg = 5;
        step("lu stall", 1, 4'b0010);
        idle();
        IF_Id_Rs = 5; EX_MemMemRead = 1; EX_MemWriteReg = 5;
        step("lu resume", 1, 4'b1100);
        check("lu stallcount", 32'(StallCount), STATS ? 32'd1 : 32'd0);
        // Branch on load: two bubbles, then run.
        idle();
        IF_Id_Branch = 1; IF_Id_Rs = 3; IF_Id_UsesRt = 1; IF_Id_Rt = 9;
        ID_Ex_MemRead = 1; ID_Ex_Regwrite = 1; ID_Ex_WriteReg = 3;
        step("brld 1", 1, 4'b0010);
        ID_Ex_MemRead = 0; ID_Ex_Regwrite = 0; ID_Ex_WriteReg = 0; EX_MemMemRead = 1; EX_MemWriteReg = 3;
        step("brld 2", 1, 4'b0010);
        EX_MemMemRead = 0; EX_MemWriteReg = 0;
        step("brld run", 1, 4'b1100);
        // Branch on ALU producer: one bubble.
        ID_Ex_Regwrite = 1; ID_Ex_WriteReg = 3;
        step("bralu 1", 1, 4'b0010);
        ID_Ex_Regwrite = 0; ID_Ex_WriteReg = 0; EX_MemWriteReg = 3;
        step("bralu run", 1, 4'b1100);
        // Memory wait with a concurrent load-use, ending in timeout.
        idle();
        doReset();
        IF_Id_Rs = 5; ID_Ex_MemRead = 1; ID_Ex_WriteReg = 5; MemReq = 1; MemReady = 0;
        for (int k = 0; k < 4; k++) begin
            step("memwait", 1, 4'b0001);
            check($sformatf("timeout after wait %0d", k), 32'(MemTimeout), 32'(k == 3));
        end
        MemReady = 1;
        step("mem ready", 1, 4'b0010);
        check("freezecount", 32'(FreezeCount), STATS ? 32'd4 : 32'd0);
        check("timeout sticky", 32'(MemTimeout), 32'd1);
        idle();
        step("post ready", 1, 4'b1100);
        check("timeout still", 32'(MemTimeout), 32'd1);
        // Reset in the middle of a wait.
        MemReq = 1;
        step("rewait", 1, 4'b0001);
        rst = 1;
        step("rst in wait", 1, 4'b1110);
        rst = 0;
        check("timeout cleared", 32'(MemTimeout), 32'd0);
        idle();
        for (int n = 0; n < 3000; n++) begin
            rst = ($urandom_range(0, 63) == 0);
            IF_Id_Rs = 5'($urandom_range(0, 3));
            IF_Id_Rt = 5'($urandom_range(0, 3));
            IF_Id_UsesRt = 1'($urandom_range(0, 1));
            IF_Id_Branch = 1'($urandom_range(0, 1));
            ID_Ex_MemRead = 1'($urandom_range(0, 1));
            ID_Ex_Regwrite = 1'($urandom_range(0, 1));
            ID_Ex_WriteReg = 5'($urandom_range(0, 3));
            EX_MemMemRead = 1'($urandom_range(0, 1));
            EX_MemWriteReg = 5'($urandom_range(0, 3));
            MemReq = ($urandom_range(0, 2) == 0);
            MemReady = ($urandom_range(0, 3) == 0);
            step("rand", 0, 4'b0000);
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
